// File: rtl/speed_set_pkg.sv
// Shared constants and helpers for the speed_set button-controlled clock divider.
package speed_set_pkg;

  localparam int unsigned NUM_SPEEDS_DEF      = 4;
  localparam int unsigned HALF_BASE_DEF       = 4;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;

  // Half-period of clk_out in clk cycles for a given speed level.
  function automatic int unsigned half_period(input int unsigned base,
                                              input int unsigned level);
    return base << level;
  endfunction

endpackage : speed_set_pkg

// File: rtl/speed_set_if.sv
// Button-in / divided-clock-out signal pair of speed_set, as seen by its user.
interface speed_set_if;

  logic speed_toggle;
  logic clk_out;

  // Button side drives speed_toggle and observes the generated clock.
  modport master (output speed_toggle, input clk_out);
  // Divider side consumes the button level and produces the clock.
  modport slave  (input speed_toggle, output clk_out);

endinterface : speed_set_if

// File: rtl/speed_set_toggle_sync.sv
// Button synchronizer and press detector.
// SPEED_SET_DEBOUNCE_EN: press fires only after DEBOUNCE_CYCLES consecutive
// synchronized high samples; otherwise a plain rising-edge detect.
module speed_set_toggle_sync
  import speed_set_pkg::*;
`ifdef SPEED_SET_DEBOUNCE_EN
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
)
`endif
(
  input  logic clk,
  input  logic reset,
  input  logic speed_toggle_i,
  output logic press_c_o
);

  logic s1_q;
  logic s2_q;

  // Two-flop synchronizer for the asynchronous button level.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= speed_toggle_i;
      s2_q <= s1_q;
    end
  end

`ifdef SPEED_SET_DEBOUNCE_EN
  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [DB_W-1:0] db_q;
  logic [DB_W-1:0] db_d;

  // Saturating count of consecutive high samples; cleared by any low sample.
  always_comb begin
    db_d = db_q;
    if (!s2_q) begin
      db_d = '0;
    end else if (db_q != DB_W'(DEBOUNCE_CYCLES)) begin
      db_d = db_q + DB_W'(1);
    end
  end

  // Debounce counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_q <= '0;
    end else begin
      db_q <= db_d;
    end
  end

  // Fires once, on the DEBOUNCE_CYCLES-th consecutive high sample.
  assign press_c_o = s2_q && (db_q == DB_W'(DEBOUNCE_CYCLES - 1));
`else
  logic prev_q;

  // Previous synchronized level for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= s2_q;
    end
  end

  assign press_c_o = s2_q & ~prev_q;
`endif

endmodule : speed_set_toggle_sync

// File: rtl/speed_set.sv
// Push-button selectable-speed clock generator: each press advances a wrapping
// speed level; clk_out is a 50% square wave with half-period HALF_BASE << level.
// Optional build macro SPEED_SET_DEBOUNCE_EN enables button debouncing.
module speed_set
  import speed_set_pkg::*;
#(
  parameter int unsigned NUM_SPEEDS      = NUM_SPEEDS_DEF,
  parameter int unsigned HALF_BASE       = HALF_BASE_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  output logic clk_out,
  input  logic speed_toggle,
  input  logic clk,
  input  logic reset
);

  localparam int unsigned LEVEL_W = $clog2(NUM_SPEEDS);
  localparam int unsigned CNT_W   = $clog2(HALF_BASE << (NUM_SPEEDS - 1)) + 1;

  logic               press_c;
  logic [LEVEL_W-1:0] level_q;
  logic [LEVEL_W-1:0] level_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [CNT_W-1:0]   half_m1_c;
  logic               clk_out_q;
  logic               clk_out_d;

  speed_set_toggle_sync
`ifdef SPEED_SET_DEBOUNCE_EN
  #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  )
`endif
  u_toggle_sync (
    .clk            (clk),
    .reset          (reset),
    .speed_toggle_i (speed_toggle),
    .press_c_o      (press_c)
  );

  assign half_m1_c = CNT_W'(half_period(HALF_BASE, 32'(level_q)) - 1);

  // A press restarts the half-period at the new rate with clk_out held;
  // otherwise the divider counts and flips clk_out at the terminal count.
  always_comb begin
    level_d   = level_q;
    cnt_d     = cnt_q;
    clk_out_d = clk_out_q;
    if (press_c) begin
      level_d = (level_q == LEVEL_W'(NUM_SPEEDS - 1)) ? '0 : level_q + LEVEL_W'(1);
      cnt_d   = '0;
    end else if (cnt_q == half_m1_c) begin
      cnt_d     = '0;
      clk_out_d = ~clk_out_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Level, divider and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_q   <= '0;
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
    end else begin
      level_q   <= level_d;
      cnt_q     <= cnt_d;
      clk_out_q <= clk_out_d;
    end
  end

  assign clk_out = clk_out_q;

endmodule : speed_set

// File: tb/tb_speed_set.sv
// Bench for speed_set: measures clk_out half-periods and compares them with
// hand-derived expectations queued by the stimulus.
// Also covers the SPEED_SET_DEBOUNCE_EN build when the macro is defined.
module tb_speed_set;
  import speed_set_pkg::*;

  localparam int HB = int'(HALF_BASE_DEF);
  // Cycles from the clk_out edge T to the level update when the button is
  // raised just after edge T+1 (sync 2 + edge detect 1, plus debounce wait).
`ifdef SPEED_SET_DEBOUNCE_EN
  localparam int PRESS_LAT = 4 + int'(DEBOUNCE_CYCLES_DEF) - 1;
`else
  localparam int PRESS_LAT = 4;
`endif

  logic clk = 1'b0;
  logic reset;

  speed_set_if sif ();

  speed_set #(
    .NUM_SPEEDS      (NUM_SPEEDS_DEF),
    .HALF_BASE       (HALF_BASE_DEF),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES_DEF)
  ) dut (
    .clk_out      (sif.clk_out),
    .speed_toggle (sif.speed_toggle),
    .clk          (clk),
    .reset        (reset)
  );

  always #5 clk = ~clk;

  int   exp_q[$];
  int   n_vec   = 0;
  int   n_err   = 0;
  int   tog_cnt = 0;
  int   run_len = 0;
  int   exp_v;
  logic last_out;
  logic rst_smp;

  // Reset as seen by the DUT on the last rising edge.
  always @(posedge clk) rst_smp <= reset;

  // Monitor: measure each clk_out half-period and check it against the queue.
  always @(negedge clk) begin
    if (rst_smp !== 1'b0) begin
      run_len  = 0;
      last_out = sif.clk_out;
    end else begin
      run_len++;
      if (sif.clk_out !== last_out) begin
        tog_cnt++;
        if (exp_q.size() > 0) begin
          exp_v = exp_q.pop_front();
          n_vec++;
          if (run_len != exp_v) begin
            n_err++;
            $display("FAIL half_period #%0d: got %0d cycles, expected %0d", n_vec, run_len, exp_v);
          end
        end
        last_out = sif.clk_out;
        run_len  = 0;
      end
    end
  end

  task automatic check_out(input string name, input logic exp);
    n_vec++;
    if (sif.clk_out !== exp) begin
      n_err++;
      $display("FAIL %s: clk_out=%b expected %b", name, sif.clk_out, exp);
    end
  endtask

  task automatic push_n(input int h, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(h);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 1500; i++) begin
      if (exp_q.size() == 0) return;
      @(posedge clk);
    end
    n_vec++;
    n_err++;
    $display("FAIL %s: %0d half-periods still pending after timeout", name, exp_q.size());
    exp_q.delete();
  endtask

  // Returns on the first rising edge after a clk_out transition.
  task automatic wait_toggle();
    int  c0;
    bit  seen;
    c0   = tog_cnt;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      if (tog_cnt != c0) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL toggle_timeout: no clk_out edge within 400 cycles");
    end
  endtask

  task automatic do_reset(input string name);
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 check_out(name, 1'b0);
    reset = 1'b0;
  endtask

  // Press aligned to a clk_out edge T; old-rate edges before the level update
  // keep h_old, the straddling half-period is the remainder plus a full h_new.
  task automatic press(input string name, input int len, input int h_old,
                       input int h_new, input int n_follow);
    int t;
    wait_toggle();
    #1 sif.speed_toggle = 1'b1;
    t = h_old;
    while (t < PRESS_LAT) begin
      exp_q.push_back(h_old);
      t += h_old;
    end
    exp_q.push_back(PRESS_LAT - (t - h_old) + h_new);
    push_n(h_new, n_follow);
    repeat (len) @(posedge clk);
    #1 sif.speed_toggle = 1'b0;
    wait_drain(name);
  endtask

  initial begin
    reset            = 1'b1;
    sif.speed_toggle = 1'b0;

    do_reset("reset_clk_out");
    push_n(HB, 4);
    wait_drain("base_rate");

`ifdef SPEED_SET_DEBOUNCE_EN
    wait_toggle();
    #1 sif.speed_toggle = 1'b1;
    repeat (2) @(posedge clk);
    #1 sif.speed_toggle = 1'b0;
    push_n(HB, 6);
    wait_drain("glitch_ignored");
`endif

    press("first_press",  10, HB,     HB * 2, 3);
    press("second_press", 10, HB * 2, HB * 4, 2);
    press("third_press",  10, HB * 4, HB * 8, 2);
    press("wrap_press",   10, HB * 8, HB,     4);
    press("hold_high",   100, HB,     HB * 2, 14);
    press("to_level2",    10, HB * 2, HB * 4, 2);
    press("to_level3",    10, HB * 4, HB * 8, 1);

    // Reset in the middle of a high level-3 half-period.
    wait_toggle();
    if (sif.clk_out !== 1'b1) wait_toggle();
    repeat (10) @(posedge clk);
    do_reset("midop_reset_clk_out");
    push_n(HB, 3);
    wait_drain("after_reset_rate");
    press("after_reset_press", 10, HB, HB * 2, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule : tb_speed_set
